spike_stim_monitor: RTL and testbench
=====================================

// Module: spike_stim_monitor
// PURPOSE
//  Clocked, synthesizable spike traffic generator and output spike counter for the network under test.
//  Issues req/ack spikes into NEURON_IN input channels in a programmable channel order and spacing.
//  Returns acks for the NEURON_OUT output channels and counts their spikes independently.
//  Sits between the control/host logic and the network top level.
// PARAMETERS
//  NEURON_IN    4   number of input spike channels driven
//  NEURON_OUT   2   number of output spike channels monitored
//  DELAY_W      16  width of interspike delay (cycles)
//  NSPK_W       8   width of spike-count-to-issue
//  CNT_W        8   width of each output spike counter
//  SYNC_STAGES  2   flop stages on ack_in and req_out (>=2)
// PORTS
//  clk        in   1                    clock
//  rst        in   1                    synchronous reset, active-high
//  start      in   1                    pulse: begin a burst (ignored while busy=1)
//  mode       in   2                    0 ascending, 1 descending, 2 fixed channel, 3 broadcast
//  start_idx  in   $clog2(NEURON_IN)    first channel of the burst
//  delay      in   DELAY_W              interspike gap in cycles; 0 is treated as 1
//  num_spikes in   NSPK_W               number of issue events in the burst
//  clear_cnt  in   1                    synchronous clear of all output counters
//  req_in     out  NEURON_IN            spike requests to the network inputs
//  ack_in     in   NEURON_IN            acks from the network inputs (async, synchronised)
//  req_out    in   NEURON_OUT           spike requests from the network outputs (async, synchronised)
//  ack_out    out  NEURON_OUT           acks to the network outputs
//  counter    out  NEURON_OUT*CNT_W     output spike counts; channel k at [k*CNT_W +: CNT_W]
//  busy       out  1                    FSM not in IDLE
//  done       out  1                    one-cycle pulse at burst end
// BEHAVIOUR
//  Reset: req_in=0, ack_out=0, counter=0, busy=0, done=0, FSM=IDLE, synchronisers=0.
//   Reset applied mid-burst aborts the burst. No done pulse is generated for the aborted burst.
//  ack_in_s, req_out_s: SYNC_STAGES-flop synchronised copies. All decisions use only the _s signals.
//  Input handshake (4-phase, per channel i):
//   - Channel i is free when req_in[i]=0 and ack_in_s[i]=0.
//   - The FSM sets req_in[i] only on a free channel.
//   - req_in[i] drops on the cycle after ack_in_s[i]=1 is sampled.
//   - Handshakes complete independently of the FSM, including while the FSM is in WAIT/IDLE.
//  FSM states: IDLE, ISSUE, WAIT, DONE.
//   IDLE:  start=1 -> idx=start_idx, rem=num_spikes.
//          Goes to DONE if num_spikes=0, else to ISSUE.
//   ISSUE: if target channel(s) free, set req_in, timer=max(delay,1), rem--, go to WAIT.
//          Otherwise stall in ISSUE; timer not loaded.
//          Mode 3 targets all channels and issues only when every channel is free.
//   WAIT:  timer-- each cycle. At timer=1: go to DONE if rem=0, else advance idx and go to ISSUE.
//          Consecutive issues are therefore >= max(delay,1)+1 cycles apart.
//   DONE:  done=1 for exactly one cycle -> IDLE.
//  idx advance: mode0 idx+1 wrapping NEURON_IN-1->0; mode1 idx-1 wrapping 0->NEURON_IN-1.
//   Modes 2 and 3: idx unchanged.
//   start_idx >= NEURON_IN is reduced modulo NEURON_IN.
//  Output side (per channel k):
//   - Rising edge of req_out_s[k]: counter[k]++ and ack_out[k]=1 on the next cycle.
//   - ack_out[k] drops on the cycle after req_out_s[k]=0 is sampled.
//   - Simultaneous edges on several channels are all counted in the same cycle.
//  Counters saturate at 2^CNT_W-1 (no wrap).
//   clear_cnt zeroes all counters; clear wins over a coincident increment.
//   Counters run regardless of FSM state.
//  start is accepted only in IDLE. start arriving during DONE is dropped.
// TESTING
//  1 mode0, start_idx=0, num_spikes=8, delay=100, ack returned 3 cycles after req
//    -> req_in channels issue as 0,1,2,3,0,1,2,3; issues 101 cycles apart; done once.
//  2 mode1, start_idx=1, num_spikes=5 -> channel order 1,0,3,2,1.
//  3 mode0, ack_in[2] held high 500 cycles, delay=10 -> FSM stalls in ISSUE on ch2.
//    busy stays 1; ch2 issue occurs only after ack drops.
//  4 req_out=2'b11 pulsed 10 times with acks echoed -> counter = {8'd10, 8'd10}.
//    300 pulses on ch0 -> counter[0]=255 (saturated).
//  5 rst asserted mid-burst -> next cycle all outputs 0, FSM IDLE, no done pulse.
//    clear_cnt coincident with a req_out edge -> counter=0.
//  6 mode3, num_spikes=2 -> req_in=4'b1111 twice.
//    num_spikes=0 -> done one cycle after start, no req_in activity.

Source files
------------

// File: rtl/spike_stim_monitor.sv
// Spike traffic generator (4-phase req/ack into the network inputs) and
// saturating spike counter with ack return on the network outputs.
module spike_stim_monitor #(
  parameter int NEURON_IN   = 4,
  parameter int NEURON_OUT  = 2,
  parameter int DELAY_W     = 16,
  parameter int NSPK_W      = 8,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  localparam int IDX_W      = (NEURON_IN > 1) ? $clog2(NEURON_IN) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [1:0]                  mode,
  input  logic [IDX_W-1:0]            start_idx,
  input  logic [DELAY_W-1:0]          delay,
  input  logic [NSPK_W-1:0]           num_spikes,
  input  logic                        clear_cnt,
  output logic [NEURON_IN-1:0]        req_in,
  input  logic [NEURON_IN-1:0]        ack_in,
  input  logic [NEURON_OUT-1:0]       req_out,
  output logic [NEURON_OUT-1:0]       ack_out,
  output logic [NEURON_OUT*CNT_W-1:0] counter,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  function automatic logic [IDX_W-1:0] advance_idx(input logic [IDX_W-1:0] idx,
                                                   input logic [1:0] m);
    logic [IDX_W-1:0] r;
    r = idx;
    case (m)
      2'd0: begin
        if (idx == IDX_W'(NEURON_IN - 1)) r = '0;
        else                              r = idx + IDX_W'(1);
      end
      2'd1: begin
        if (idx == '0) r = IDX_W'(NEURON_IN - 1);
        else           r = idx - IDX_W'(1);
      end
      default: r = idx;
    endcase
    return r;
  endfunction

  logic [SYNC_STAGES-1:0][NEURON_IN-1:0]  ack_sync_r;
  logic [SYNC_STAGES-1:0][NEURON_OUT-1:0] req_sync_r;
  logic [NEURON_IN-1:0]  ack_in_s;
  logic [NEURON_OUT-1:0] req_out_s;
  logic [NEURON_OUT-1:0] req_out_prev_r;
  logic [NEURON_OUT-1:0] rise_s;

  state_t               state_r, state_next_s;
  logic [IDX_W-1:0]     idx_r, idx_next_s;
  logic [NSPK_W-1:0]    rem_r, rem_next_s;
  logic [DELAY_W-1:0]   timer_r, timer_next_s;
  logic [DELAY_W-1:0]   delay_r, delay_next_s;
  logic [1:0]           mode_r, mode_next_s;
  logic [IDX_W-1:0]     start_idx_mod_s;
  logic [NEURON_IN-1:0] target_s, chan_free_s, set_req_s;
  logic [NEURON_IN-1:0] req_in_r;
  logic [NEURON_OUT-1:0] ack_out_r;
  logic [CNT_W-1:0]     cnt_r [NEURON_OUT];
  logic                 busy_r, done_r;

  assign ack_in_s        = ack_sync_r[SYNC_STAGES-1];
  assign req_out_s       = req_sync_r[SYNC_STAGES-1];
  assign rise_s          = req_out_s & ~req_out_prev_r;
  assign chan_free_s     = ~req_in_r & ~ack_in_s;
  assign start_idx_mod_s = IDX_W'(int'(start_idx) % NEURON_IN);

  // Synchroniser chains for the asynchronous handshake inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_sync_r <= '0;
      req_sync_r <= '0;
    end else begin
      ack_sync_r <= {ack_sync_r[SYNC_STAGES-2:0], ack_in};
      req_sync_r <= {req_sync_r[SYNC_STAGES-2:0], req_out};
    end
  end

  // Channel mask addressed by the current issue
  always_comb begin
    target_s = '0;
    if (mode_r == 2'd3) target_s = '1;
    else                target_s = NEURON_IN'(1) << idx_r;
  end

  // Burst sequencer next-state logic
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    rem_next_s   = rem_r;
    timer_next_s = timer_r;
    delay_next_s = delay_r;
    mode_next_s  = mode_r;
    set_req_s    = '0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          idx_next_s   = start_idx_mod_s;
          rem_next_s   = num_spikes;
          mode_next_s  = mode;
          delay_next_s = (delay == '0) ? DELAY_W'(1) : delay;
          state_next_s = (num_spikes == '0) ? ST_DONE : ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // Broadcast only fires when every channel is free at once
        if ((chan_free_s & target_s) == target_s) begin
          set_req_s    = target_s;
          timer_next_s = delay_r;
          rem_next_s   = rem_r - NSPK_W'(1);
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (timer_r <= DELAY_W'(1)) begin
          if (rem_r == '0) begin
            state_next_s = ST_DONE;
          end else begin
            idx_next_s   = advance_idx(idx_r, mode_r);
            state_next_s = ST_ISSUE;
          end
        end else begin
          timer_next_s = timer_r - DELAY_W'(1);
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Sequencer state and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= '0;
      rem_r   <= '0;
      timer_r <= '0;
      delay_r <= '0;
      mode_r  <= 2'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      idx_r   <= idx_next_s;
      rem_r   <= rem_next_s;
      timer_r <= timer_next_s;
      delay_r <= delay_next_s;
      mode_r  <= mode_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
      done_r  <= (state_next_s == ST_DONE);
    end
  end

  // Input-side handshakes complete on their own once a request is raised
  always_ff @(posedge clk) begin
    if (rst) begin
      req_in_r <= '0;
    end else begin
      for (int i = 0; i < NEURON_IN; i++) begin
        if (set_req_s[i])     req_in_r[i] <= 1'b1;
        else if (ack_in_s[i]) req_in_r[i] <= 1'b0;
        else                  req_in_r[i] <= req_in_r[i];
      end
    end
  end

  // Output-side ack return and saturating spike counters
  always_ff @(posedge clk) begin
    if (rst) begin
      req_out_prev_r <= '0;
      ack_out_r      <= '0;
      for (int k = 0; k < NEURON_OUT; k++) cnt_r[k] <= '0;
    end else begin
      req_out_prev_r <= req_out_s;
      for (int k = 0; k < NEURON_OUT; k++) begin
        if (rise_s[k])          ack_out_r[k] <= 1'b1;
        else if (!req_out_s[k]) ack_out_r[k] <= 1'b0;
        else                    ack_out_r[k] <= ack_out_r[k];
        if (clear_cnt)                            cnt_r[k] <= '0;
        else if (rise_s[k] && (cnt_r[k] != '1))   cnt_r[k] <= cnt_r[k] + CNT_W'(1);
        else                                      cnt_r[k] <= cnt_r[k];
      end
    end
  end

  for (genvar g = 0; g < NEURON_OUT; g++) begin : g_cnt
    assign counter[g*CNT_W +: CNT_W] = cnt_r[g];
  end

  assign req_in  = req_in_r;
  assign ack_out = ack_out_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_spike_stim_monitor.sv
// Directed bench for spike_stim_monitor: a 3-cycle ack responder on the input
// side, an issue logger, and per-scenario tasks with hand-computed expectations.
module tb_spike_stim_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [1:0]  start_idx = 2'd0;
  logic [15:0] delay = 16'd0;
  logic [7:0]  num_spikes = 8'd0;
  logic        clear_cnt = 1'b0;
  logic [3:0]  req_in;
  logic [3:0]  ack_in = 4'd0;
  logic [1:0]  req_out = 2'd0;
  logic [1:0]  ack_out;
  logic [15:0] counter;
  logic        busy, done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  spike_stim_monitor dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .start_idx(start_idx),
    .delay(delay), .num_spikes(num_spikes), .clear_cnt(clear_cnt),
    .req_in(req_in), .ack_in(ack_in), .req_out(req_out), .ack_out(ack_out),
    .counter(counter), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Network-input model: ack follows req three cycles later, plus forced holds
  logic [3:0] p0 = 4'd0, p1 = 4'd0, p2 = 4'd0, ack_force = 4'd0;
  always @(negedge clk) begin
    ack_in <= p2 | ack_force;
    p2 <= p1;
    p1 <= p0;
    p0 <= req_in;
  end

  // Issue logger and done-pulse counter
  logic [3:0] prev_req = 4'd0;
  int         iss_cyc[$];
  logic [3:0] iss_val[$];
  int         done_cnt = 0;
  always @(negedge clk) begin
    if ((req_in & ~prev_req) != 4'd0) begin
      iss_cyc.push_back(cyc);
      iss_val.push_back(req_in & ~prev_req);
    end
    prev_req <= req_in;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [1:0] m, input logic [1:0] si,
                          input logic [15:0] d, input logic [7:0] n);
    @(negedge clk);
    mode = m; start_idx = si; delay = d; num_spikes = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s: done=%b after %0d cycles, required 1", name, done, budget);
    end
  endtask

  task automatic pulse_out(input logic [1:0] m, output bit ok);
    int k;
    ok = 1'b1;
    req_out = req_out | m;
    k = 0;
    while ((ack_out & m) !== m && k < 20) begin @(negedge clk); k++; end
    if ((ack_out & m) !== m) ok = 1'b0;
    req_out = req_out & ~m;
    k = 0;
    while ((ack_out & m) !== 2'd0 && k < 20) begin @(negedge clk); k++; end
    if ((ack_out & m) !== 2'd0) ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++; if (req_in !== 4'd0)   begin failures++; $display("FAIL rst_req_in: got %h want 0", req_in); end
    checks++; if (ack_out !== 2'd0)  begin failures++; $display("FAIL rst_ack_out: got %b want 0", ack_out); end
    checks++; if (counter !== 16'd0) begin failures++; $display("FAIL rst_counter: got %h want 0", counter); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_busy_done: got %b%b want 00", busy, done); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_ascending();
    logic [3:0] exp_v [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    int dc0;
    iss_cyc.delete(); iss_val.delete();
    dc0 = done_cnt;
    do_start(2'd0, 2'd0, 16'd100, 8'd8);
    wait_done(1200, "asc_done");
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL asc_busy_in_done: got %b want 1", busy); end
    tick(3);
    checks++; if (iss_val.size() != 8) begin failures++; $display("FAIL asc_count: got %0d issues want 8", iss_val.size()); end
    for (int i = 0; i < 8; i++) begin
      if (i < iss_val.size()) begin
        checks++;
        if (iss_val[i] !== exp_v[i]) begin failures++; $display("FAIL asc_order[%0d]: got %h want %h", i, iss_val[i], exp_v[i]); end
        if (i > 0) begin
          checks++;
          if (iss_cyc[i] - iss_cyc[i-1] != 101) begin failures++; $display("FAIL asc_gap[%0d]: got %0d want 101", i, iss_cyc[i] - iss_cyc[i-1]); end
        end
      end
    end
    checks++; if (done_cnt - dc0 != 1) begin failures++; $display("FAIL asc_done_count: got %0d want 1", done_cnt - dc0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL asc_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_descending();
    logic [3:0] exp_v [5] = '{4'h2, 4'h1, 4'h8, 4'h4, 4'h2};
    iss_cyc.delete(); iss_val.delete();
    do_start(2'd1, 2'd1, 16'd5, 8'd5);
    wait_done(300, "desc_done");
    tick(3);
    checks++; if (iss_val.size() != 5) begin failures++; $display("FAIL desc_count: got %0d want 5", iss_val.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < iss_val.size()) begin
        checks++;
        if (iss_val[i] !== exp_v[i]) begin failures++; $display("FAIL desc_order[%0d]: got %h want %h", i, iss_val[i], exp_v[i]); end
      end
    end
  endtask

  task automatic test_stall();
    logic [3:0] exp_v [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
    int rel;
    iss_cyc.delete(); iss_val.delete();
    ack_force = 4'b0100;
    tick(4);
    do_start(2'd0, 2'd0, 16'd10, 8'd4);
    tick(200);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stall_busy: got %b want 1", busy); end
    checks++; if (iss_val.size() != 2) begin failures++; $display("FAIL stall_count: got %0d want 2", iss_val.size()); end
    tick(300);
    rel = cyc;
    ack_force = 4'd0;
    wait_done(300, "stall_done");
    tick(3);
    checks++; if (iss_val.size() != 4) begin failures++; $display("FAIL stall_total: got %0d want 4", iss_val.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < iss_val.size()) begin
        checks++;
        if (iss_val[i] !== exp_v[i]) begin failures++; $display("FAIL stall_order[%0d]: got %h want %h", i, iss_val[i], exp_v[i]); end
      end
    end
    if (iss_cyc.size() > 2) begin
      checks++;
      if (iss_cyc[2] <= rel) begin failures++; $display("FAIL stall_ch2_time: got cycle %0d want > %0d", iss_cyc[2], rel); end
    end
  endtask

  task automatic test_counters();
    bit ok, all_ok;
    all_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin pulse_out(2'b11, ok); all_ok &= ok; end
    checks++; if (!all_ok) begin failures++; $display("FAIL cnt_handshake: got timeout want ack cycle"); end
    checks++; if (counter !== 16'h0A0A) begin failures++; $display("FAIL cnt_both10: got %h want 0a0a", counter); end
    all_ok = 1'b1;
    for (int i = 0; i < 300; i++) begin pulse_out(2'b01, ok); all_ok &= ok; end
    checks++; if (!all_ok) begin failures++; $display("FAIL cnt_handshake_ch0: got timeout want ack cycle"); end
    checks++; if (counter[7:0] !== 8'd255) begin failures++; $display("FAIL cnt_saturate: got %0d want 255", counter[7:0]); end
    checks++; if (counter[15:8] !== 8'd10) begin failures++; $display("FAIL cnt_ch1_hold: got %0d want 10", counter[15:8]); end
  endtask

  task automatic test_reset_mid_burst();
    int dc0, n0;
    do_start(2'd0, 2'd0, 16'd50, 8'd8);
    tick(20);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_pre_busy: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (req_in !== 4'd0 || ack_out !== 2'd0) begin failures++; $display("FAIL midrst_req_ack: got %h/%b want 0/0", req_in, ack_out); end
    checks++; if (counter !== 16'd0) begin failures++; $display("FAIL midrst_counter: got %h want 0", counter); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrst_busy_done: got %b%b want 00", busy, done); end
    rst = 1'b0;
    dc0 = done_cnt;
    n0 = iss_val.size();
    tick(200);
    checks++; if (done_cnt != dc0) begin failures++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt - dc0); end
    checks++; if (iss_val.size() != n0) begin failures++; $display("FAIL midrst_no_issue: got %0d issues want 0", iss_val.size() - n0); end
  endtask

  task automatic test_clear_coincident();
    bit ok, all_ok;
    all_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin pulse_out(2'b10, ok); all_ok &= ok; end
    checks++; if (!all_ok || counter !== 16'h0300) begin failures++; $display("FAIL clr_setup: got %h want 0300", counter); end
    // Synchronised edge reaches the counter on the third rising clock edge
    req_out = 2'b01;
    tick(2);
    clear_cnt = 1'b1;
    tick(1);
    clear_cnt = 1'b0;
    checks++; if (counter !== 16'd0) begin failures++; $display("FAIL clr_wins: got %h want 0", counter); end
    checks++; if (ack_out !== 2'b01) begin failures++; $display("FAIL clr_ack: got %b want 01", ack_out); end
    req_out = 2'b00;
    tick(6);
    checks++; if (counter !== 16'd0 || ack_out !== 2'd0) begin failures++; $display("FAIL clr_after: got %h/%b want 0/0", counter, ack_out); end
  endtask

  task automatic test_broadcast();
    int n0;
    iss_cyc.delete(); iss_val.delete();
    do_start(2'd3, 2'd0, 16'd5, 8'd2);
    wait_done(300, "bcast_done");
    tick(3);
    checks++; if (iss_val.size() != 2) begin failures++; $display("FAIL bcast_count: got %0d want 2", iss_val.size()); end
    for (int i = 0; i < 2; i++) begin
      if (i < iss_val.size()) begin
        checks++;
        if (iss_val[i] !== 4'hF) begin failures++; $display("FAIL bcast_val[%0d]: got %h want f", i, iss_val[i]); end
      end
    end
    tick(20);
    n0 = iss_val.size();
    do_start(2'd0, 2'd0, 16'd5, 8'd0);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done: got %b want 1", done); end
    tick(1);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL zero_after: got done=%b busy=%b want 0 0", done, busy); end
    tick(10);
    checks++; if (iss_val.size() != n0) begin failures++; $display("FAIL zero_no_issue: got %0d issues want 0", iss_val.size() - n0); end
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_descending();
    test_stall();
    test_counters();
    test_reset_mid_burst();
    test_clear_coincident();
    test_broadcast();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
